// File: rtl/board_gen_pkg.sv
// Shared Flood-It board constants, FSM state type and LFSR step helper.
package board_pkg;

  localparam int unsigned MAX_SIZE   = 14;
  localparam int unsigned MAX_COLORS = 8;
  localparam int unsigned CELL_W     = $clog2(MAX_COLORS);

  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  localparam int unsigned TAP_A = 15;
  localparam int unsigned TAP_B = 13;
  localparam int unsigned TAP_C = 12;
  localparam int unsigned TAP_D = 10;

  typedef enum logic [1:0] {IDLE, SEED, FILL, DONE} state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
  endfunction

endpackage

// File: rtl/board_gen_if.sv
// Selector <-> board generator handshake plus board RAM write port.
interface board_gen_if #(
  parameter int unsigned SIZE_W = 4,
  parameter int unsigned CELL_W = 3,
  parameter int unsigned LFSR_W = 16
);
  logic              INIT_NEW_BOARD;
  logic [SIZE_W-1:0] SIZE;
  logic [CELL_W:0]   COLOR_NUM;
  logic [LFSR_W-1:0] SEED;
  logic              BOARD_READY;
  logic              BUSY;
  logic              WR_EN;
  logic [SIZE_W-1:0] WR_ROW;
  logic [SIZE_W-1:0] WR_COL;
  logic [CELL_W-1:0] WR_COLOR;

  modport master (
    output INIT_NEW_BOARD, SIZE, COLOR_NUM, SEED,
    input  BOARD_READY, BUSY, WR_EN, WR_ROW, WR_COL, WR_COLOR
  );

  modport slave (
    input  INIT_NEW_BOARD, SIZE, COLOR_NUM, SEED,
    output BOARD_READY, BUSY, WR_EN, WR_ROW, WR_COL, WR_COLOR
  );
endinterface

// File: rtl/board_gen_lfsr16.sv
// 16-bit Fibonacci LFSR with load and step; a zero load value is replaced by LFSR_RESET.
module lfsr16
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? LFSR_RESET : seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_RESET;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/board_gen.sv
// Random Flood-It board generator: streams one colour per cell, row-major.
// Optional macro BOARD_GEN_FREE_RUN_EN: LFSR free-runs and the SEED input is ignored.
module board_gen #(
  parameter int unsigned MAX_SIZE   = 14,
  parameter int unsigned MAX_COLORS = 8,
  parameter int unsigned LFSR_W     = 16,
  parameter int unsigned SIZE_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  board_gen_if.slave bus
);
  import board_pkg::*;

  localparam int unsigned CELL_W = $clog2(MAX_COLORS);
  localparam int unsigned NCOL_W = CELL_W + 1;

  state_e            state_q, state_d;
  logic [SIZE_W-1:0] size_q, size_d, row_q, row_d, col_q, col_d;
  logic [NCOL_W-1:0] ncol_q, ncol_d;
  logic              ready_q, ready_d, busy_q, busy_d, wr_en_q, wr_en_d;
  logic [SIZE_W-1:0] wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [CELL_W-1:0] wr_color_q, wr_color_d;

  logic              lfsr_load, lfsr_step;
  logic [LFSR_W-1:0] lfsr_val;
  logic [CELL_W-1:0] cand;

  assign cand = lfsr_val[CELL_W-1:0];

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .step (lfsr_step),
    .seed (bus.SEED),
    .q    (lfsr_val)
  );

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    ncol_d     = ncol_q;
    row_d      = row_q;
    col_d      = col_q;
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_color_d = wr_color_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    case (state_q)
      IDLE: if (bus.INIT_NEW_BOARD) state_d = SEED;
      SEED: begin
        if (!bus.INIT_NEW_BOARD) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          if (bus.SIZE < SIZE_W'(2))             size_d = SIZE_W'(2);
          else if (bus.SIZE > SIZE_W'(MAX_SIZE)) size_d = SIZE_W'(MAX_SIZE);
          else                                   size_d = bus.SIZE;
          if (bus.COLOR_NUM < NCOL_W'(2))               ncol_d = NCOL_W'(2);
          else if (bus.COLOR_NUM > NCOL_W'(MAX_COLORS)) ncol_d = NCOL_W'(MAX_COLORS);
          else                                          ncol_d = bus.COLOR_NUM;
          row_d = '0;
          col_d = '0;
`ifndef BOARD_GEN_FREE_RUN_EN
          lfsr_load = 1'b1;
`endif
          state_d = FILL;
        end
      end
      FILL: begin
        if (!bus.INIT_NEW_BOARD) begin
          state_d = IDLE;
        end else begin
          busy_d    = 1'b1;
          lfsr_step = 1'b1;
          // Rejection sampling: out-of-range candidates just burn a cycle.
          if ({1'b0, cand} < ncol_q) begin
            wr_en_d    = 1'b1;
            wr_row_d   = row_q;
            wr_col_d   = col_q;
            wr_color_d = cand;
            if (col_q == size_q - SIZE_W'(1)) begin
              col_d = '0;
              if (row_q == size_q - SIZE_W'(1)) state_d = DONE;
              else                              row_d   = row_q + SIZE_W'(1);
            end else begin
              col_d = col_q + SIZE_W'(1);
            end
          end
        end
      end
      DONE: begin
        if (bus.INIT_NEW_BOARD) ready_d = 1'b1;
        else                    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef BOARD_GEN_FREE_RUN_EN
    lfsr_step = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      size_q     <= '0;
      ncol_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_color_q <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      ncol_q     <= ncol_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_color_q <= wr_color_d;
    end
  end

  assign bus.BOARD_READY = ready_q;
  assign bus.BUSY        = busy_q;
  assign bus.WR_EN       = wr_en_q;
  assign bus.WR_ROW      = wr_row_q;
  assign bus.WR_COL      = wr_col_q;
  assign bus.WR_COLOR    = wr_color_q;

endmodule

// File: tb/tb_board_gen.sv
// Self-checking bench for board_gen: table of board requests scored against a reference LFSR model.
module tb_board_gen;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned CELL_W = 3;
  localparam int unsigned LFSR_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  board_gen_if #(.SIZE_W(SIZE_W), .CELL_W(CELL_W), .LFSR_W(LFSR_W)) bus ();

  board_gen #(.MAX_SIZE(14), .MAX_COLORS(8), .LFSR_W(16), .SIZE_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int row;
    int col;
    int color;
    int cyc;
  } wr_t;

  typedef struct {
    logic [15:0] seed;
    logic [3:0]  size;
    logic [3:0]  cnum;
    int          esz;
    int          enc;
  } vec_t;

  wr_t exp_q[$];
  wr_t got_q[$];
  wr_t ref_q[$];
  int  total = 0;
  int  bad   = 0;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one request and scores every cycle until DONE, holds INIT, then withdraws it.
  task automatic run_board(input logic [15:0] seed, input logic [3:0] sz, input logic [3:0] cn,
                           input int esz, input int enc, input int hold);
    logic [15:0] l;
    int k, last, cyc;
    bit exp_en;
    wr_t e, g;
    exp_q.delete();
    got_q.delete();
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    k = 0;
    for (int r = 0; r < esz; r++) begin
      for (int c = 0; c < esz; c++) begin
        while (int'(l[2:0]) >= enc) begin
          l = lfsr_nx(l);
          k++;
        end
        e.row = r; e.col = c; e.color = int'(l[2:0]); e.cyc = 3 + k;
        exp_q.push_back(e);
        l = lfsr_nx(l);
        k++;
      end
    end
    last = exp_q[$].cyc;
    bus.SEED = seed;
    bus.SIZE = sz;
    bus.COLOR_NUM = cn;
    bus.INIT_NEW_BOARD = 1'b1;
    cyc = 0;
    while (cyc < last && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        bus.SIZE = 4'd7;
        bus.COLOR_NUM = 4'd2;
      end
      exp_en = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("wr_en", int'(bus.WR_EN), int'(exp_en));
      chk("busy", int'(bus.BUSY), int'(cyc >= 2));
      chk("ready_early", int'(bus.BOARD_READY), 0);
      if (exp_en) begin
        e = exp_q.pop_front();
        chk("wr_row", int'(bus.WR_ROW), e.row);
        chk("wr_col", int'(bus.WR_COL), e.col);
        chk("wr_color", int'(bus.WR_COLOR), e.color);
      end
      if (bus.WR_EN) begin
        g.row = int'(bus.WR_ROW); g.col = int'(bus.WR_COL);
        g.color = int'(bus.WR_COLOR); g.cyc = cyc;
        got_q.push_back(g);
      end
    end
    chk("writes_left", exp_q.size(), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("ready_hold", int'(bus.BOARD_READY), 1);
      chk("busy_done", int'(bus.BUSY), 0);
      chk("wr_en_done", int'(bus.WR_EN), 0);
    end
    bus.INIT_NEW_BOARD = 1'b0;
    @(negedge clk);
    chk("ready_drop", int'(bus.BOARD_READY), 0);
    chk("busy_idle", int'(bus.BUSY), 0);
  endtask

  task automatic cmp_ref(input string name);
    chk({name, "_len"}, got_q.size(), ref_q.size());
    if (got_q.size() == ref_q.size()) begin
      for (int i = 0; i < got_q.size(); i++) begin
        if (got_q[i].row != ref_q[i].row || got_q[i].col != ref_q[i].col ||
            got_q[i].color != ref_q[i].color || got_q[i].cyc != ref_q[i].cyc) begin
          chk({name, "_entry"}, i, -1);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int n, maxc, cyc;

    vecs[0] = '{16'hACE1, 4'd3,  4'd6,  3,  6};
    vecs[1] = '{16'h1234, 4'd14, 4'd8,  14, 8};
    vecs[2] = '{16'hBEEF, 4'd0,  4'd1,  2,  2};
    vecs[3] = '{16'h0001, 4'd15, 4'd15, 14, 8};
    vecs[4] = '{16'h5A5A, 4'd5,  4'd3,  5,  3};
    vecs[5] = '{16'h0000, 4'd3,  4'd6,  3,  6};

    rst_n = 1'b0;
    bus.INIT_NEW_BOARD = 1'b0;
    bus.SIZE = '0;
    bus.COLOR_NUM = '0;
    bus.SEED = '0;
    #3;
    chk("rst_ready", int'(bus.BOARD_READY), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_wr_en", int'(bus.WR_EN), 0);
    chk("rst_wr_row", int'(bus.WR_ROW), 0);
    chk("rst_wr_col", int'(bus.WR_COL), 0);
    chk("rst_wr_color", int'(bus.WR_COLOR), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_board(vecs[v].seed, vecs[v].size, vecs[v].cnum, vecs[v].esz, vecs[v].enc, (v == 0) ? 10 : 2);
      chk("write_count", got_q.size(), vecs[v].esz * vecs[v].esz);
      maxc = 0;
      foreach (got_q[i]) if (got_q[i].color > maxc) maxc = got_q[i].color;
      chk("color_range", int'(maxc < vecs[v].enc), 1);
      if (v == 0) begin
        ref_q = got_q;
        chk("first_color0", got_q[0].color, 1);
        chk("first_cyc0", got_q[0].cyc, 3);
        chk("first_col1", got_q[1].col, 1);
        chk("first_color1", got_q[1].color, 3);
        chk("first_cyc1", got_q[1].cyc, 4);
        chk("first_col2", got_q[2].col, 2);
        chk("first_color2", got_q[2].color, 4);
        chk("first_cyc2", got_q[2].cyc, 8);
      end
      if (v == 1) begin
        chk("full_count", got_q.size(), 196);
        chk("full_last_row", got_q[$].row, 13);
        chk("full_last_col", got_q[$].col, 13);
        chk("full_no_reject", got_q[$].cyc, 198);
      end
      if (v == 5) cmp_ref("seed_zero");
    end

    run_board(16'hACE1, 4'd3, 4'd6, 3, 6, 1);
    cmp_ref("repeat_seed");

    // Abort after five writes.
    bus.SEED = 16'h1357;
    bus.SIZE = 4'd14;
    bus.COLOR_NUM = 4'd8;
    bus.INIT_NEW_BOARD = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.WR_EN) n++;
    end
    chk("abort_writes", n, 5);
    bus.INIT_NEW_BOARD = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("abort_wr_en", int'(bus.WR_EN), 0);
      chk("abort_ready", int'(bus.BOARD_READY), 0);
      chk("abort_busy", int'(bus.BUSY), 0);
    end
    run_board(16'h1357, 4'd14, 4'd8, 14, 8, 1);
    chk("restart_row", got_q[0].row, 0);
    chk("restart_col", got_q[0].col, 0);

    // Asynchronous reset in the middle of a fill.
    bus.SEED = 16'hACE1;
    bus.SIZE = 4'd5;
    bus.COLOR_NUM = 4'd4;
    bus.INIT_NEW_BOARD = 1'b1;
    cyc = 0;
    while (!(bus.WR_EN && bus.WR_COL != '0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_fill_reached", int'(bus.WR_EN && bus.WR_COL != '0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", int'(bus.WR_EN), 0);
    chk("arst_wr_col", int'(bus.WR_COL), 0);
    chk("arst_wr_row", int'(bus.WR_ROW), 0);
    chk("arst_wr_color", int'(bus.WR_COLOR), 0);
    chk("arst_busy", int'(bus.BUSY), 0);
    chk("arst_ready", int'(bus.BOARD_READY), 0);
    bus.INIT_NEW_BOARD = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_board(16'hACE1, 4'd5, 4'd4, 5, 4, 1);
    chk("post_reset_count", got_q.size(), 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
